// File: rtl/bird_motion_pkg.sv
// Shared definitions for the bird motion controller and the 640x480 colour stage.
// Holds state encodings, screen geometry and the row-coordinate width.
package bird_motion_pkg;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int Y_W      = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_FLY  = 2'b01,
      ST_DEAD = 2'b10
   } state_e;

endpackage

// File: rtl/bird_motion_btn_edge_sync.sv
// Two-flop synchronizer for an asynchronous button followed by a rising-edge
// detector that produces a single-cycle pulse in the clk_i domain.
module btn_edge_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic edge_o
);

   // [0],[1] form the synchronizer; [2] remembers the previous synchronized level.
   logic [2:0] sync_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[1:0], btn_i};
      end
   end

   assign edge_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/bird_motion.sv
// Per-frame vertical motion controller for the player square: applies flap,
// gravity and screen boundaries once per frame_tick and reports game state.
module bird_motion
   import bird_motion_pkg::*;
#(
   parameter int START_Y     = 232,
   parameter int BIRD_SIZE   = 16,
   parameter int GROUND_Y    = V_ACTIVE,
   parameter int FLAP_VEL    = -8,
   parameter int GRAVITY     = 1,
   parameter int MAX_FALL    = 8,
   parameter int DEAD_FRAMES = 60
) (
   input  logic                  dclk,
   input  logic                  clr,
   input  logic                  frame_tick,
   input  logic                  flap_btn,
   output logic [Y_W-1:0]        bird_y,
   output logic signed [5:0]     bird_vel,
   output logic [1:0]            state,
   output logic                  dead
);

   localparam int CNT_W = $clog2(DEAD_FRAMES + 1);

   localparam logic [Y_W-1:0]    START_Y_C = Y_W'(START_Y);
   localparam logic [Y_W-1:0]    FLOOR_Y_C = Y_W'(GROUND_Y - BIRD_SIZE);
   localparam logic signed [10:0] FLOOR_Y_S = 11'(GROUND_Y - BIRD_SIZE);
   localparam logic signed [6:0] FLAP_V    = 7'(FLAP_VEL);
   localparam logic signed [6:0] GRAV_V    = 7'(GRAVITY);
   localparam logic signed [6:0] MAX_V     = 7'(MAX_FALL);
   localparam logic [CNT_W-1:0]  DEAD_CNT  = CNT_W'(DEAD_FRAMES);

   logic [Y_W-1:0]     y_q, y_d;
   logic signed [5:0]  vel_q, vel_d;
   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               pend_q, pend_d;

   logic               flap_edge;
   logic               flap;
   logic signed [6:0]  vel_sum;
   logic signed [6:0]  vel_new;
   logic signed [10:0] y_new;
   logic [Y_W-1:0]     fly_y;
   logic signed [5:0]  fly_vel;
   logic               fly_hit_ground;

   btn_edge_sync u_flap_sync (
      .clk_i  (dclk),
      .rst_i  (clr),
      .btn_i  (flap_btn),
      .edge_o (flap_edge)
   );

   always_ff @(posedge dclk or posedge clr) begin
      if (clr) begin
         y_q     <= START_Y_C;
         vel_q   <= '0;
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
      end else begin
         y_q     <= y_d;
         vel_q   <= vel_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
      end
   end

   // An edge landing in the tick cycle itself still counts as this frame's flap.
   assign flap = pend_q | flap_edge;

   always_comb begin
      vel_sum = $signed({vel_q[5], vel_q}) + GRAV_V;
      vel_new = flap ? FLAP_V : ((vel_sum > MAX_V) ? MAX_V : vel_sum);
      y_new   = $signed({1'b0, y_q}) + $signed({{4{vel_new[6]}}, vel_new});

      fly_hit_ground = 1'b0;
      if (y_new < 11'sd0) begin
         fly_y   = '0;
         fly_vel = '0;
      end else if (y_new >= FLOOR_Y_S) begin
         fly_y          = FLOOR_Y_C;
         fly_vel        = '0;
         fly_hit_ground = 1'b1;
      end else begin
         fly_y   = y_new[Y_W-1:0];
         fly_vel = vel_new[5:0];
      end
   end

   // NOTE: every next-state signal is given its hold value first so no path infers a latch.
   always_comb begin
      y_d     = y_q;
      vel_d   = vel_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q | flap_edge;

      if (frame_tick) begin
         pend_d = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (flap) begin
                  state_d = ST_FLY;
                  y_d     = fly_y;
                  vel_d   = fly_vel;
               end
            end
            ST_FLY: begin
               y_d   = fly_y;
               vel_d = fly_vel;
               if (fly_hit_ground) begin
                  state_d = ST_DEAD;
                  cnt_d   = '0;
               end
            end
            ST_DEAD: begin
               if (cnt_q != DEAD_CNT) begin
                  cnt_d = cnt_q + 1'b1;
               end else if (flap) begin
                  state_d = ST_IDLE;
                  y_d     = START_Y_C;
                  vel_d   = '0;
               end
            end
            default: begin
               state_d = ST_IDLE;
               y_d     = START_Y_C;
               vel_d   = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign bird_y   = y_q;
   assign bird_vel = vel_q;
   assign state    = state_q;
   assign dead     = (state_q == ST_DEAD);

endmodule

// File: tb/tb_bird_motion.sv
// Self-checking bench for bird_motion: directed scenarios plus randomized flap
// patterns compared against a frame-level behavioural model.
module tb_bird_motion;

   localparam int START_Y     = 232;
   localparam int BIRD_SIZE   = 16;
   localparam int GROUND_Y    = 480;
   localparam int FLAP_VEL    = -8;
   localparam int GRAVITY     = 1;
   localparam int MAX_FALL    = 8;
   localparam int DEAD_FRAMES = 60;

   logic             dclk = 1'b0;
   logic             clr = 1'b0;
   logic             frame_tick = 1'b0;
   logic             flap_btn = 1'b0;
   logic [9:0]       bird_y;
   logic signed [5:0] bird_vel;
   logic [1:0]       state;
   logic             dead;

   int checks = 0;
   int failures = 0;

   // Frame-level reference model: position, velocity, state (0 idle, 1 fly, 2 dead), dead-frame count.
   int m_y, m_v, m_st, m_cnt;

   bird_motion dut (
      .dclk       (dclk),
      .clr        (clr),
      .frame_tick (frame_tick),
      .flap_btn   (flap_btn),
      .bird_y     (bird_y),
      .bird_vel   (bird_vel),
      .state      (state),
      .dead       (dead)
   );

   always #5 dclk = ~dclk;

   task automatic model_reset();
      m_y = START_Y; m_v = 0; m_st = 0; m_cnt = 0;
   endtask

   task automatic model_step(input bit flap);
      int nv, ny;
      if (m_st == 0 && flap) begin
         m_st = 1;
         m_v  = 0;
         m_y  = START_Y;
      end else if (m_st == 0) begin
         return;
      end
      if (m_st == 1) begin
         nv = flap ? FLAP_VEL : ((m_v + GRAVITY > MAX_FALL) ? MAX_FALL : m_v + GRAVITY);
         ny = m_y + nv;
         if (ny < 0) begin
            m_y = 0; m_v = 0;
         end else if (ny + BIRD_SIZE >= GROUND_Y) begin
            m_y = GROUND_Y - BIRD_SIZE; m_v = 0; m_st = 2; m_cnt = 0;
         end else begin
            m_y = ny; m_v = nv;
         end
      end else begin
         if (m_cnt == DEAD_FRAMES && flap) begin
            m_st = 0; m_y = START_Y; m_v = 0;
         end else if (m_cnt < DEAD_FRAMES) begin
            m_cnt = m_cnt + 1;
         end
      end
   endtask

   // Caller is at a negedge; returns at a negedge with the button released and settled.
   task automatic press();
      flap_btn = 1'b1;
      repeat (2) @(negedge dclk);
      flap_btn = 1'b0;
      repeat (3) @(negedge dclk);
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      @(negedge dclk);
      frame_tick = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge dclk);
      clr = 1'b1;
      flap_btn = 1'b0;
      frame_tick = 1'b0;
      @(negedge dclk);
      clr = 1'b0;
      model_reset();
   endtask

   task automatic run_frame(input bit flap, input string tag);
      if (flap) press();
      checks++;
      if (bird_y !== 10'(m_y) || bird_vel !== 6'(m_v) || state !== 2'(m_st)) begin
         failures++;
         $display("FAIL %s_hold: y=%0d vel=%0d st=%0d expected y=%0d vel=%0d st=%0d",
                  tag, bird_y, bird_vel, state, m_y, m_v, m_st);
      end
      tick();
      model_step(flap);
      checks++;
      if (bird_y !== 10'(m_y) || bird_vel !== 6'(m_v) || state !== 2'(m_st)
          || dead !== (m_st == 2)) begin
         failures++;
         $display("FAIL %s: y=%0d vel=%0d st=%0d dead=%0b expected y=%0d vel=%0d st=%0d dead=%0b",
                  tag, bird_y, bird_vel, state, dead, m_y, m_v, m_st, (m_st == 2));
      end
   endtask

   task automatic test_reset();
      #1 clr = 1'b1;
      #1;
      checks++;
      if (bird_y !== 10'd232 || bird_vel !== 6'sd0 || state !== 2'b00 || dead !== 1'b0) begin
         failures++;
         $display("FAIL reset_initial: y=%0d vel=%0d st=%0d dead=%0b expected 232 0 0 0",
                  bird_y, bird_vel, state, dead);
      end
      @(negedge dclk);
      clr = 1'b0;
      model_reset();
      run_frame(1'b1, "reset_fly1");
      run_frame(1'b0, "reset_fly2");
      @(negedge dclk);
      #1 clr = 1'b1;
      #1;
      checks++;
      if (bird_y !== 10'd232 || bird_vel !== 6'sd0 || state !== 2'b00 || dead !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_fly: y=%0d vel=%0d st=%0d dead=%0b expected 232 0 0 0",
                  bird_y, bird_vel, state, dead);
      end
      @(negedge dclk);
      clr = 1'b0;
      model_reset();
   endtask

   task automatic test_first_flap();
      do_reset();
      run_frame(1'b1, "first_flap");
      checks++;
      if (bird_y !== 10'd224 || bird_vel !== -6'sd8 || state !== 2'b01) begin
         failures++;
         $display("FAIL first_flap_const: y=%0d vel=%0d st=%0d expected 224 -8 1", bird_y, bird_vel, state);
      end
      run_frame(1'b0, "glide1");
      run_frame(1'b0, "glide2");
      checks++;
      if (bird_y !== 10'd211 || bird_vel !== -6'sd6) begin
         failures++;
         $display("FAIL glide2_const: y=%0d vel=%0d expected 211 -6", bird_y, bird_vel);
      end
   endtask

   task automatic test_coincident();
      do_reset();
      // Raise the button so its synchronized edge lands in the tick cycle.
      flap_btn = 1'b1;
      @(negedge dclk);
      @(negedge dclk);
      frame_tick = 1'b1;
      @(negedge dclk);
      frame_tick = 1'b0;
      flap_btn = 1'b0;
      repeat (3) @(negedge dclk);
      model_step(1'b1);
      checks++;
      if (bird_y !== 10'd224 || state !== 2'b01) begin
         failures++;
         $display("FAIL coincident_edge: y=%0d st=%0d expected 224 1", bird_y, state);
      end
      run_frame(1'b0, "after_coincident");
      do_reset();
      press();
      press();
      tick();
      model_step(1'b1);
      checks++;
      if (bird_y !== 10'd224 || bird_vel !== -6'sd8) begin
         failures++;
         $display("FAIL double_press: y=%0d vel=%0d expected 224 -8", bird_y, bird_vel);
      end
   endtask

   task automatic test_ceiling();
      do_reset();
      for (int i = 1; i <= 30; i++) run_frame(1'b1, "ceiling");
      checks++;
      if (bird_y !== 10'd0 || bird_vel !== 6'sd0 || state !== 2'b01) begin
         failures++;
         $display("FAIL ceiling_clamp: y=%0d vel=%0d st=%0d expected 0 0 1", bird_y, bird_vel, state);
      end
   endtask

   task automatic test_ground();
      int frames;
      do_reset();
      run_frame(1'b1, "ground_flap");
      frames = 0;
      while (m_st != 2 && frames < 200) begin
         run_frame(1'b0, "ground_fall");
         frames++;
      end
      checks++;
      if (bird_y !== 10'd464 || bird_vel !== 6'sd0 || state !== 2'b10 || dead !== 1'b1) begin
         failures++;
         $display("FAIL ground_dead: y=%0d vel=%0d st=%0d dead=%0b after %0d frames expected 464 0 2 1",
                  bird_y, bird_vel, state, dead, frames);
      end
   endtask

   // Continues from the DEAD state left by test_ground.
   task automatic test_restart();
      for (int i = 0; i < DEAD_FRAMES; i++) begin
         run_frame((i == DEAD_FRAMES - 1) ? 1'b1 : 1'($urandom_range(0, 1)), "dead_wait");
      end
      checks++;
      if (state !== 2'b10 || dead !== 1'b1) begin
         failures++;
         $display("FAIL dead_hold: st=%0d dead=%0b expected 2 1", state, dead);
      end
      run_frame(1'b0, "dead_noflap");
      run_frame(1'b1, "restart");
      checks++;
      if (state !== 2'b00 || bird_y !== 10'd232 || dead !== 1'b0) begin
         failures++;
         $display("FAIL restart_idle: st=%0d y=%0d dead=%0b expected 0 232 0", state, bird_y, dead);
      end
      run_frame(1'b0, "idle_after_restart");
      run_frame(1'b1, "refly");
      checks++;
      if (state !== 2'b01 || bird_y !== 10'd224) begin
         failures++;
         $display("FAIL refly: st=%0d y=%0d expected 1 224", state, bird_y);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 300; i++) begin
         repeat ($urandom_range(0, 4)) @(negedge dclk);
         run_frame(($urandom_range(0, 2) == 0), "random");
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      test_reset();
      test_first_flap();
      test_coincident();
      test_ceiling();
      test_ground();
      test_restart();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bird_motion.md
Name: bird_motion

Overview:
- Per-frame vertical motion controller for the player square.
- Sits directly upstream of the 640x480 pixel/colour stage. It takes a once-per-frame tick from the sync timing counters and a raw flap button, and produces the registered bird Y position and game state.
- The colour stage compares bird_y against the vertical counter to draw the square.
- All updates occur once per frame so the position is stable for the whole active video period.

Parameters:
- START_Y, 232, Y position (pixels, top edge) in IDLE and after restart.
- BIRD_SIZE, 16, square height in pixels.
- GROUND_Y, 480, first row below the playfield; bird dies when bottom edge reaches it.
- FLAP_VEL, -8, signed velocity (px/frame) loaded on a flap.
- GRAVITY, 1, velocity increment per frame without flap.
- MAX_FALL, 8, maximum downward velocity (px/frame).
- DEAD_FRAMES, 60, frames DEAD must persist before restart is accepted.

Ports:
- dclk  in  1  pixel clock, 25 MHz; the only clock.
- clr  in  1  reset, asynchronous, active-high.
- frame_tick  in  1  one-cycle pulse per frame, issued by the timing generator at the start of vertical blanking.
- flap_btn  in  1  raw, asynchronous, active-high button.
- bird_y  out  10  unsigned top-edge row of the square, 0..GROUND_Y-BIRD_SIZE.
- bird_vel  out  6  signed current velocity (two's complement, positive = down).
- state  out  2  00 IDLE, 01 FLY, 10 DEAD.
- dead  out  1  high while state==DEAD.

Behaviour:
- Clocking and reset: clk = dclk. clr is asynchronous, active-high. On clr, regardless of in-progress activity:
  - bird_y=START_Y, bird_vel=0, state=IDLE, dead=0.
  - Synchronizer and flap_pending cleared; dead counter = 0.
- Button path:
  - 2-FF synchronizer, then rising-edge detect (1-cycle pulse).
  - The edge sets flap_pending. flap_pending is cleared on every frame_tick, whether used or discarded.
  - The effective flap for a tick is flap_pending OR the edge pulse in the same cycle, so an edge coinciding with frame_tick is not lost.
  - Multiple edges in one frame count as one flap.
- Update timing: all state/position/velocity updates happen only in the cycle frame_tick=1. Outputs are registered and valid the next cycle. Outputs are held constant between ticks.
- Arithmetic:
  - New velocity v' is computed in 7-bit signed: v' = FLAP_VEL on flap, else min(v+GRAVITY, MAX_FALL).
  - New position y' = bird_y + v' is computed in 11-bit signed.
- IDLE:
  - bird_y=START_Y, vel=0.
  - Tick with flap -> FLY, applying the first FLY update in that same tick: vel=FLAP_VEL, y=START_Y+FLAP_VEL.
  - Tick without flap -> stay.
- FLY, on each tick:
  - Compute v' and y'.
  - Top boundary: if y'<0, bird_y=0 and vel=0.
  - Ground boundary: else if y'+BIRD_SIZE >= GROUND_Y, bird_y=GROUND_Y-BIRD_SIZE, vel=0, state=DEAD, dead counter=0.
  - Otherwise bird_y=y', vel=v'.
  - The top clamp takes priority; both boundaries cannot hold simultaneously with legal parameters.
- DEAD:
  - bird_y and vel hold; dead=1.
  - The counter increments each tick, saturating at DEAD_FRAMES.
  - Flaps are discarded while counter<DEAD_FRAMES.
  - Once counter==DEAD_FRAMES, a tick with flap -> IDLE (bird_y=START_Y, vel=0). That flap does not also start FLY.
- Illegal state encoding 11 -> IDLE on next tick.
- Parameter legality: START_Y+BIRD_SIZE<GROUND_Y, GROUND_Y<=1023, |FLAP_VEL|,MAX_FALL<=31.

Decomposition:
- Shared package: state encodings (ST_IDLE/ST_FLY/ST_DEAD), screen constants (480 active lines, 640 active columns), and the bird_y width (10). The colour stage uses the same package.
- One sub-module is natural: btn_edge_sync (2-FF synchronizer + rising-edge pulse, async clr). It is reusable for future buttons.
- The rest is a single always block for the FSM/datapath.

Test Plan:
- Reset: assert clr mid-FLY -> next cycle bird_y=232, bird_vel=0, state=00, dead=0, even with no dclk edge during clr.
- First flap: press, then tick -> state=01, bird_vel=-8, bird_y=224. Next tick without flap -> vel=-7, y=217. Next -> vel=-6, y=211.
- Edge coincident with frame_tick: edge and tick in the same cycle from IDLE -> FLY, y=224. Two presses within one frame -> single flap (y=224, not 216).
- Ceiling: flap every frame from IDLE -> y=224,216,…,0 on tick 29. Tick 30 -> y=0, vel=0, state stays 01.
- Ground: after one flap, no further flaps -> vel saturates at 8. When y'+16>=480 -> bird_y=464, vel=0, state=10, dead=1.
- Restart: in DEAD, flap before tick 60 -> stays DEAD. After 60 ticks, flap+tick -> state=00, bird_y=232. A further flap+tick -> FLY, y=224.
